// File: rtl/demux_1x256_reg_pkg.sv
// Constants and state encoding shared between the 256:1 select mux and its write-side demux.
package demux_1x256_reg_pkg;

    localparam int MUX_SEL_W = 8;
    localparam int MUX_N     = 1 << MUX_SEL_W;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

endpackage

// File: rtl/demux_1x256_reg_bit_index_counter.sv
// Wrapping SEL_W-bit index counter with synchronous clear, count enable and terminal-count flag.
module bit_index_counter #(
    parameter int SEL_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [SEL_W-1:0] cnt_o,
    output logic             tc_o
);

    logic [SEL_W-1:0] cnt_q;
    logic [SEL_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = &cnt_q;

endmodule

// File: rtl/demux_1x256_reg.sv
// Registered 1:256 demux: steers din into one bit of a 256-bit holding register,
// either at an explicit select or by a sequential fill of the whole vector.
module demux_1x256_reg
    import demux_1x256_reg_pkg::*;
#(
    parameter int SEL_W = MUX_SEL_W,
    parameter int N     = MUX_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic [SEL_W-1:0] sel,
    input  logic             wr_en,
    input  logic             mode,
    input  logic             start,
    output logic [N-1:0]     out,
    output logic [SEL_W-1:0] idx,
    output logic             busy,
    output logic             done
);

    fill_state_e      state_q, state_d;
    logic [N-1:0]     out_q, out_d;
    logic             done_q, done_d;
    logic             cnt_clr, cnt_en, cnt_tc;
    logic [SEL_W-1:0] idx_q;

    bit_index_counter #(.SEL_W(SEL_W)) u_idx (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (idx_q),
        .tc_o  (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE: begin
                // A sequential start takes priority over a same-cycle addressed write.
                if (start && mode) begin
                    state_d = FILL;
                    out_d   = '0;
                    cnt_clr = 1'b1;
                end else if (wr_en) begin
                    out_d[sel] = din;
                end
            end
            FILL: begin
                if (wr_en) begin
                    out_d[idx_q] = din;
                    cnt_en       = 1'b1;
                    if (cnt_tc) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign out  = out_q;
    assign idx  = idx_q;
    assign busy = (state_q == FILL);
    assign done = done_q;

endmodule

// File: tb/tb_demux_1x256_reg.sv
// Randomized and directed check of demux_1x256_reg against a behavioural model of the fill rules.
module tb_demux_1x256_reg;

    logic         clk = 1'b0;
    logic         rst, din, wr_en, mode, start;
    logic [7:0]   sel;
    logic [255:0] out;
    logic [7:0]   idx;
    logic         busy, done;

    demux_1x256_reg dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .sel   (sel),
        .wr_en (wr_en),
        .mode  (mode),
        .start (start),
        .out   (out),
        .idx   (idx),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural model: a bit array, a fill position and a "filling" flag.
    logic [255:0] m_out;
    int           m_pos;
    bit           m_filling, m_done, m_valid = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_out = '0; m_pos = 0; m_filling = 0; m_done = 0; m_valid = 1;
        end else if (m_valid) begin
            m_done = 0;
            if (!m_filling) begin
                if (start && mode) begin
                    m_filling = 1; m_out = '0; m_pos = 0;
                end else if (wr_en) begin
                    m_out[sel] = din;
                end
            end else if (wr_en) begin
                m_out[m_pos] = din;
                m_pos = (m_pos + 1) % 256;
                if (m_pos == 0) begin
                    m_filling = 0; m_done = 1;
                end
            end
        end
    end

    int done_seen = 0;
    always @(negedge clk) begin
        if (m_valid) begin
            chk("out",  out,                 m_out);
            chk("idx",  {248'd0, idx},       256'(m_pos));
            chk("busy", {255'd0, busy},      {255'd0, m_filling});
            chk("done", {255'd0, done},      {255'd0, m_done});
            if (done) done_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]   pat;
        logic [255:0] fill_exp;
        pat      = 8'b1010_0011;
        fill_exp = {128{2'b10}};

        // Reset held with a write request active
        rst = 1; wr_en = 1; din = 1; sel = 8'd3; mode = 0; start = 0;
        tick(); tick();
        chk("reset_out", out, 256'd0);
        chk("reset_busy_done_idx", {246'd0, busy, done, idx}, 256'd0);
        rst = 0;

        // Addressed fill of the low byte
        for (int s = 0; s < 8; s++) begin
            sel = 8'(s); din = pat[s]; wr_en = 1; tick();
        end
        wr_en = 0;
        chk("addr_low_byte", {248'd0, out[7:0]}, 256'h0A3);
        chk("addr_upper_zero", {8'd0, out[255:8]}, 256'd0);

        // Highest select position set, then cleared
        sel = 8'hFF; din = 1; wr_en = 1; tick();
        chk("addr_bit255_set", out, {1'b1, 247'd0, 8'hA3});
        din = 0; tick();
        chk("addr_bit255_clr", out, {248'd0, 8'hA3});

        // start collides with an addressed write: start wins
        sel = 8'd200; din = 1; wr_en = 1; start = 1; mode = 1; tick();
        start = 0;
        chk("collide_out", out, 256'd0);
        chk("collide_busy", {255'd0, busy}, 256'd1);

        // Sequential fill with a 3-cycle stall at index 100; sel/start/mode wiggled
        done_seen = 0;
        for (int i = 0; i < 256; i++) begin
            if (i == 100) begin
                for (int k = 0; k < 3; k++) begin
                    wr_en = 0; start = 1; mode = 1; din = 1; sel = 8'($urandom);
                    tick();
                    chk("stall_idx", {248'd0, idx}, 256'd100);
                end
            end
            wr_en = 1; din = i[0]; sel = 8'($urandom);
            start = (i < 255) ? 1'($urandom) : 1'b0; mode = 1'($urandom);
            tick();
        end
        wr_en = 0; start = 0;
        chk("fill_out", out, fill_exp);
        chk("fill_done", {255'd0, done}, 256'd1);
        chk("fill_end_idx_busy", {247'd0, busy, idx}, 256'd0);
        tick(); tick();
        chk("done_one_pulse", 256'(done_seen), 256'd1);

        // Reset part-way through a fill
        start = 1; mode = 1; tick(); start = 0;
        for (int i = 0; i < 40; i++) begin
            wr_en = 1; din = 1'($urandom); tick();
        end
        chk("mid_idx40", {248'd0, idx}, 256'd40);
        done_seen = 0;
        rst = 1; wr_en = 1; din = 1; tick();
        rst = 0; wr_en = 0;
        chk("midrst_state", {246'd0, busy, done, idx}, 256'd0);
        chk("midrst_out", out, 256'd0);
        sel = 8'd77; din = 1; wr_en = 1; tick(); wr_en = 0;
        chk("post_rst_write", out, 256'd1 << 77);
        tick();
        chk("midrst_no_done", 256'(done_seen), 256'd0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 255) == 0);
            din   = 1'($urandom);
            sel   = 8'($urandom);
            wr_en = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 15) == 0);
            mode  = 1'($urandom);
            tick();
        end
        rst = 0; wr_en = 0; start = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/demux_1x256_reg.md
Name: demux_1x256_reg

Overview:
- Registered 1-to-256 demultiplexer: the write-side counterpart of the 256:1 select mux.
- Steers a single serial bit `din` into one position of a 256-bit holding register `out`.
- Two ways to choose the position:
  - addressed mode: an explicit select `sel`;
  - sequential mode: an internal auto-incrementing index that fills the whole vector.
- Used to build the 256-bit operand word that the mux later reads back bit by bit.

Parameters:
- SEL_W, 8, select/index width in bits.
- N, 256, output vector width; must equal 2**SEL_W.

Ports:
- clk    input   1      system clock, all state on rising edge
- rst    input   1      synchronous reset, active-high
- din    input   1      serial data bit to be steered
- sel    input   SEL_W  target bit position in addressed mode
- wr_en  input   1      write strobe (addressed write, or fill-beat in sequential mode)
- mode   input   1      0 = addressed, 1 = sequential; sampled only when start is seen
- start  input   1      begin a sequential fill (only acted on in IDLE with mode=1)
- out    output  N      registered demux vector
- idx    output  SEL_W  current sequential write index
- busy   output  1      high while a sequential fill is in progress
- done   output  1      single-cycle pulse after the last fill beat

Behaviour:
- Interface decision: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - out=0, idx=0, busy=0, done=0, state=IDLE.
  - rst overrides every other input, including mid-fill; a partial fill is discarded.
- States: IDLE, FILL.
- IDLE, addressed write (wr_en=1, and not (start=1 with mode=1)):
  - out[sel] <= din at the next edge; all other bits hold.
  - Latency: 1 clock.
- IDLE, start=1 and mode=1:
  - Next state FILL; out <= 0; idx <= 0; busy <= 1.
  - A wr_en asserted in the same cycle is ignored (start wins).
- IDLE, start=1 and mode=0: no action other than a normal addressed write if wr_en=1.
- FILL:
  - wr_en=1: out[idx] <= din, then idx <= idx+1.
  - wr_en=0: stall; idx and out hold.
  - sel and start are ignored; start while busy has no effect.
- FILL, last beat (wr_en=1 with idx==N-1):
  - Write out[N-1]; idx wraps to 0.
  - Next state IDLE; busy <= 0; done <= 1 for exactly one cycle.
- done:
  - Registered; asserted in the cycle the FSM returns to IDLE.
  - Cleared the following cycle unconditionally.
- Width rules:
  - idx increments modulo 2**SEL_W, with no overflow flag.
  - sel is a full-range index; every value 0..N-1 is legal.
- out is never combinationally dependent on inputs; it changes only at clock edges.

Decomposition:
- Shared package (e.g. mux_pkg) holds:
  - SEL_W and N constants, shared with the 256:1 mux;
  - the state encoding IDLE=1'b0, FILL=1'b1.
- One natural sub-module, `bit_index_counter`: SEL_W-bit counter with synchronous clear, enable and a terminal-count output.
- The write-decode and vector register stay in the top module.

Test Plan:
- Reset check: assert rst for 2 cycles with wr_en=1, din=1 -> out=0, idx=0, busy=0, done=0 throughout.
- Addressed fill: write the pattern 8'b1010_0011 via sel=0..7 (din = bit sel), one write per cycle -> out[7:0]=8'hA3 and out[255:8]=0 one cycle after the last write.
- Addressed high index: sel=8'hFF, din=1 -> out[255]=1 next edge; a repeat with din=0 clears it; all other bits unchanged.
- Sequential fill with stalls:
  - Stimulus: start with mode=1, then 256 beats of din=idx[0], with wr_en deasserted for 3 cycles at idx=100.
  - Required: out = {128{2'b10}}; busy high throughout; idx holds at 100 during the stall; done pulses exactly once; idx=0 afterwards.
- Collisions:
  - start and wr_en together in IDLE -> no write occurs, FSM enters FILL.
  - start and sel changes while busy -> ignored.
  - An addressed write attempted during FILL does not touch out[sel].
- Reset mid-fill: rst at idx=40 -> out=0, idx=0, busy=0, no done pulse; a subsequent addressed write works normally.
